// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the UART receive monitor.
//   parity_e    : parity mode selector for the receiver
//   rx_state_e  : receiver FSM state encoding
//   rx_frame_t  : one decoded frame with its error flags (data is 9 bits wide to cover all widths)
//   calc_div()  : rounded clock divider for the oversampling tick
//   maj3()      : 2-of-3 majority vote used for mid-bit sampling
package sim_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic       brk;
        logic       frame_err;
        logic       parity_err;
        logic [8:0] data;
    } rx_frame_t;

    // round(clk_hz / (baud * os)); returns 0 on a degenerate denominator
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        longint den;
        den = baud * os;
        if (den <= 0) return 0;
        return int'((clk_hz + den / 2) / den);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sim_uart_rx_fifo.sv
// Synchronous frame FIFO with a valid/ready drain port.
//   i_clk, i_nrst : clock, async active-low reset
//   i_push, i_din : write request and word; a push on full without a same-cycle pop is dropped
//   o_valid       : head word present
//   i_ready       : consumer takes the head when o_valid is high
//   o_dout        : head word; holds the last popped word while empty
//   o_full        : occupancy equals DEPTH
//   o_level       : occupancy
module sim_uart_rx_fifo #(
    parameter int  WIDTH = 12,
    parameter int  DEPTH = 8,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_pop;
    logic             w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == LW'(DEPTH));
    assign o_level = r_count;
    assign w_pop   = o_valid & i_ready;
    // a pop in the same cycle frees the slot, so a push on full is still accepted
    assign w_wr    = i_push & (~o_full | w_pop);
    assign o_dout  = o_valid ? r_mem[r_rd_ptr] : r_last;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sim_uart_rx_monitor.sv
// Passive UART receive monitor: oversamples i_rx, decodes frames and queues them with error flags.
//   i_clk, i_nrst : clock, async active-low reset
//   i_rx          : serial line (idle high, asynchronous to i_clk)
//   i_enable      : receiver enable; low aborts any frame in progress
//   o_valid/i_ready, o_data, o_parity_err, o_frame_err, o_break : FIFO head and drain handshake
//   o_level       : FIFO occupancy
//   o_overflow    : sticky, a completed frame was dropped on a full FIFO; cleared by i_ovf_clr
// Optional macro SIM_UART_RX_MONITOR_LOG_EN adds simulation logging of pushed and dropped frames.
//
// state     | meaning
// RX_IDLE   | waiting for a falling edge on the synchronised line, tick counter held at 0
// RX_START  | validating the start bit at mid-bit; a high majority is a glitch
// RX_DATA   | shifting DATA_BITS bits, LSB first
// RX_PARITY | checking the parity bit against the received data
// RX_STOP   | sampling STOP_BITS stop bits; the frame completes at mid of the last one
module sim_uart_rx_monitor
    import sim_uart_pkg::*;
#(
    parameter int      CLK_FREQUENCY_HZ = 50_000_000,
    parameter int      BAUDRATE         = 115200,
    parameter int      OVERSAMPLE       = 16,
    parameter int      DATA_BITS        = 8,
    parameter parity_e PARITY           = PAR_NONE,
    parameter int      STOP_BITS        = 1,
    parameter int      FIFO_DEPTH       = 8
) (
    input  logic                              i_clk,
    input  logic                              i_nrst,
    input  logic                              i_rx,
    input  logic                              i_enable,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [DATA_BITS-1:0]              o_data,
    output logic                              o_parity_err,
    output logic                              o_frame_err,
    output logic                              o_break,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
    output logic                              o_overflow,
    input  logic                              i_ovf_clr
);

    localparam int DIV   = calc_div(CLK_FREQUENCY_HZ, BAUDRATE, OVERSAMPLE);
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int FW    = DATA_BITS + 3;
    localparam int LW    = $clog2(FIFO_DEPTH + 1);

    if (DIV < 1) begin : g_div_chk
        $error("sim_uart_rx_monitor: CLK_FREQUENCY_HZ too low for BAUDRATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
        $error("sim_uart_rx_monitor: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
        $error("sim_uart_rx_monitor: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_sb_chk
        $error("sim_uart_rx_monitor: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fd_chk
        $error("sim_uart_rx_monitor: FIFO_DEPTH must be a power of 2, >= 2");
    end

    rx_state_e      r_state;
    logic [1:0]     r_sync;
    logic           r_rx_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [OS_W-1:0]  r_samp;
    logic           r_s0;
    logic           r_s1;
    logic [3:0]     r_bitcnt;
    logic           r_stopcnt;
    logic [8:0]     r_shift;
    logic           r_par_err;
    logic           r_frm_err;
    logic           r_push;
    logic [FW-1:0]  r_push_word;
    logic           r_ovf;

    logic           w_rx;
    logic           w_fall;
    logic           w_tick;
    logic           w_decide;
    logic           w_bit_end;
    logic           w_bit;
    logic           w_frm_final;
    logic           w_valid;
    logic           w_full;
    logic           w_drop;
    logic [FW-1:0]  w_head;

    assign w_rx      = r_sync[1];
    assign w_fall    = r_rx_prev & ~w_rx;
    assign w_tick    = (r_state != RX_IDLE) && (r_div_cnt == DIV_W'(DIV - 1));
    assign w_decide  = w_tick && (r_samp == OS_W'(OVERSAMPLE / 2 + 1));
    assign w_bit_end = w_tick && (r_samp == OS_W'(OVERSAMPLE - 1));
    // the third vote is the live sample taken at the decision tick
    assign w_bit     = maj3(r_s0, r_s1, w_rx);
    assign w_frm_final = r_frm_err | ~w_bit;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sync      <= 2'b11;
            r_rx_prev   <= 1'b1;
            r_state     <= RX_IDLE;
            r_div_cnt   <= '0;
            r_samp      <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_bitcnt    <= '0;
            r_stopcnt   <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx;
            r_push    <= 1'b0;

            if (r_state == RX_IDLE) begin
                r_div_cnt <= '0;
                r_samp    <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                if (r_samp == OS_W'(OVERSAMPLE - 1)) r_samp <= '0;
                else                                 r_samp <= r_samp + OS_W'(1);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (w_tick && r_samp == OS_W'(OVERSAMPLE / 2 - 1)) r_s0 <= w_rx;
            if (w_tick && r_samp == OS_W'(OVERSAMPLE / 2))     r_s1 <= w_rx;

            if (r_state != RX_IDLE && !i_enable) begin
                r_state <= RX_IDLE;
            end else begin
                case (r_state)
                    RX_IDLE: begin
                        if (i_enable && w_fall) begin
                            r_state   <= RX_START;
                            r_div_cnt <= '0;
                            r_samp    <= '0;
                            r_bitcnt  <= '0;
                            r_stopcnt <= 1'b0;
                            r_shift   <= '0;
                            r_par_err <= 1'b0;
                            r_frm_err <= 1'b0;
                        end
                    end
                    RX_START: begin
                        if (w_decide && w_bit) begin
                            r_state <= RX_IDLE;
                        end else if (w_bit_end) begin
                            r_state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (w_decide) begin
                            r_shift[r_bitcnt] <= w_bit;
                        end
                        if (w_bit_end) begin
                            if (r_bitcnt == 4'(DATA_BITS - 1)) begin
                                r_bitcnt <= '0;
                                r_state  <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (w_decide) begin
                            r_par_err <= ((^r_shift) ^ w_bit) != (PARITY == PAR_ODD);
                        end
                        if (w_bit_end) begin
                            r_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (w_decide) begin
                            if (STOP_BITS == 1 || r_stopcnt) begin
                                // completing at mid-stop lets the next start edge be caught in time
                                r_state     <= RX_IDLE;
                                r_push      <= 1'b1;
                                r_push_word <= {w_frm_final && (r_shift == '0), w_frm_final,
                                                r_par_err, r_shift[DATA_BITS-1:0]};
                            end else begin
                                r_frm_err <= w_frm_final;
                            end
                        end
                        if (w_bit_end) begin
                            r_stopcnt <= 1'b1;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    sim_uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (r_push),
        .i_din   (r_push_word),
        .o_valid (w_valid),
        .i_ready (i_ready),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_level (o_level)
    );

    assign w_drop = r_push & w_full & ~(w_valid & i_ready);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_valid      = w_valid;
    assign o_data       = w_head[DATA_BITS-1:0];
    assign o_parity_err = w_head[DATA_BITS];
    assign o_frame_err  = w_head[DATA_BITS+1];
    assign o_break      = w_head[DATA_BITS+2];
    assign o_overflow   = r_ovf;

`ifdef SIM_UART_RX_MONITOR_LOG_EN
    always @(posedge i_clk) begin
        if (i_nrst && r_push) begin
            $display("%t uart_rx: data=0x%0h par=%b frm=%b brk=%b", $time,
                     r_push_word[DATA_BITS-1:0], r_push_word[DATA_BITS],
                     r_push_word[DATA_BITS+1], r_push_word[DATA_BITS+2]);
        end
        if (i_nrst && w_drop) begin
            $warning("uart_rx: overflow");
        end
    end
`endif

endmodule

// File: tb/tb_sim_uart_rx_monitor.sv
`timescale 1ns/1ps
module tb_sim_uart_rx_monitor;
    import sim_uart_pkg::*;

    // 3.6864 MHz / (115200 * 16) = 2 exactly, so one bit is 32 clocks
    localparam int CLK_HZ  = 3_686_400;
    localparam int BAUD    = 115200;
    localparam int OS      = 16;
    localparam int DIV     = 2;
    localparam int BIT_CYC = DIV * OS;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic rx_n = 1'b1, rx_e = 1'b1;
    logic ready_n = 1'b0, ready_e = 1'b0;
    logic clr_n = 1'b0, clr_e = 1'b0;

    logic       valid_n, par_n, frm_n, brk_n, ovf_n;
    logic [7:0] data_n;
    logic [2:0] level_n;
    logic       valid_e, par_e, frm_e, brk_e, ovf_e;
    logic [7:0] data_e;
    logic [2:0] level_e;

    int n_cmp = 0;
    int n_bad = 0;
    rx_frame_t q_n[$];
    rx_frame_t q_e[$];

    always #5 clk = ~clk;

    sim_uart_rx_monitor #(
        .CLK_FREQUENCY_HZ(CLK_HZ), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_n (
        .i_clk(clk), .i_nrst(rst_n), .i_rx(rx_n), .i_enable(en),
        .o_valid(valid_n), .i_ready(ready_n), .o_data(data_n),
        .o_parity_err(par_n), .o_frame_err(frm_n), .o_break(brk_n),
        .o_level(level_n), .o_overflow(ovf_n), .i_ovf_clr(clr_n)
    );

    sim_uart_rx_monitor #(
        .CLK_FREQUENCY_HZ(CLK_HZ), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_e (
        .i_clk(clk), .i_nrst(rst_n), .i_rx(rx_e), .i_enable(en),
        .o_valid(valid_e), .i_ready(ready_e), .o_data(data_e),
        .o_parity_err(par_e), .o_frame_err(frm_e), .o_break(brk_e),
        .o_level(level_e), .o_overflow(ovf_e), .i_ovf_clr(clr_e)
    );

    function automatic rx_frame_t mk(input logic [8:0] d, input logic p, input logic f, input logic b);
        rx_frame_t r;
        r.data = d; r.parity_err = p; r.frame_err = f; r.brk = b;
        return r;
    endfunction

    // drive n line bits LSB first, one bit time each, then return the line to idle
    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_e = bits[i]; else rx_n = bits[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        if (sel) rx_e = 1'b1; else rx_n = 1'b1;
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_bits(1'b0, {6'b0, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic send_8e1(input logic [7:0] d, input logic p);
        send_bits(1'b1, {5'b0, 1'b1, p, d, 1'b0}, 11);
    endtask

    // wait (bounded) for a head, capture it, then pop it with a one-cycle ready
    task automatic pop_frame(input bit sel, output rx_frame_t f, output bit got);
        got = 1'b0;
        f = '0;
        for (int i = 0; i < 16 * BIT_CYC && !got; i++) begin
            @(negedge clk);
            if (sel ? valid_e : valid_n) got = 1'b1;
        end
        if (got) begin
            f = sel ? mk({1'b0, data_e}, par_e, frm_e, brk_e) : mk({1'b0, data_n}, par_n, frm_n, brk_n);
            if (sel) ready_e = 1'b1; else ready_n = 1'b1;
            @(negedge clk);
            ready_e = 1'b0;
            ready_n = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({valid_n, data_n, par_n, frm_n, brk_n, level_n, ovf_n} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_n: got v=%b d=0x%0h p=%b f=%b b=%b lvl=%0d ovf=%b, expected all 0",
                     valid_n, data_n, par_n, frm_n, brk_n, level_n, ovf_n);
        end
        n_cmp++;
        if ({valid_e, data_e, par_e, frm_e, brk_e, level_e, ovf_e} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_e: got v=%b d=0x%0h p=%b f=%b b=%b lvl=%0d ovf=%b, expected all 0",
                     valid_e, data_e, par_e, frm_e, brk_e, level_e, ovf_e);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (valid_n !== 1'b0 || level_n !== 3'd0) begin
            n_bad++;
            $display("FAIL post_reset: got v=%b lvl=%0d, expected v=0 lvl=0", valid_n, level_n);
        end
    endtask

    task automatic test_basic_8n1();
        rx_frame_t exp, obs;
        bit got;
        q_n.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
        send_8n1(8'hA5);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (level_n !== 3'd1) begin
            n_bad++;
            $display("FAIL basic_level: got %0d, expected 1", level_n);
        end
        exp = q_n.pop_front();
        pop_frame(1'b0, obs, got);
        n_cmp++;
        if (!got || obs !== exp) begin
            n_bad++;
            $display("FAIL basic_frame: got(seen=%b) d=0x%0h p=%b f=%b b=%b, expected d=0x%0h p=%b f=%b b=%b",
                     got, obs.data, obs.parity_err, obs.frame_err, obs.brk,
                     exp.data, exp.parity_err, exp.frame_err, exp.brk);
        end
    endtask

    task automatic test_parity_even();
        rx_frame_t exp, obs;
        bit got;
        // 0x03 has even ones -> parity bit 1 is wrong; 0x07 has odd ones -> parity bit 1 is right
        q_e.push_back(mk(9'h003, 1'b1, 1'b0, 1'b0));
        q_e.push_back(mk(9'h007, 1'b0, 1'b0, 1'b0));
        send_8e1(8'h03, 1'b1);
        send_8e1(8'h07, 1'b1);
        for (int k = 0; k < 2; k++) begin
            exp = q_e.pop_front();
            pop_frame(1'b1, obs, got);
            n_cmp++;
            if (!got || obs !== exp) begin
                n_bad++;
                $display("FAIL parity_frame%0d: got(seen=%b) d=0x%0h p=%b f=%b b=%b, expected d=0x%0h p=%b f=%b b=%b",
                         k, got, obs.data, obs.parity_err, obs.frame_err, obs.brk,
                         exp.data, exp.parity_err, exp.frame_err, exp.brk);
            end
        end
    endtask

    task automatic test_break();
        rx_frame_t exp, obs;
        bit got;
        q_n.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
        send_bits(1'b0, 16'h0000, 10);
        exp = q_n.pop_front();
        pop_frame(1'b0, obs, got);
        n_cmp++;
        if (!got || obs !== exp) begin
            n_bad++;
            $display("FAIL break_frame: got(seen=%b) d=0x%0h p=%b f=%b b=%b, expected d=0x%0h p=%b f=%b b=%b",
                     got, obs.data, obs.parity_err, obs.frame_err, obs.brk,
                     exp.data, exp.parity_err, exp.frame_err, exp.brk);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx_n = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx_n = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        n_cmp++;
        if (level_n !== 3'd0 || valid_n !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_level: got lvl=%0d v=%b, expected lvl=0 v=0", level_n, valid_n);
        end
        n_cmp++;
        if (dut_n.r_state !== RX_IDLE) begin
            n_bad++;
            $display("FAIL glitch_state: got %0d, expected %0d", dut_n.r_state, RX_IDLE);
        end
    endtask

    task automatic test_overflow();
        rx_frame_t exp, obs;
        bit got;
        for (int b = 1; b <= 5; b++) begin
            if (b <= DEPTH) q_n.push_back(mk(9'(b * 8'h11), 1'b0, 1'b0, 1'b0));
            send_8n1(8'(b * 8'h11));
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (level_n !== 3'd4 || ovf_n !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_full: got lvl=%0d ovf=%b, expected lvl=4 ovf=1", level_n, ovf_n);
        end
        for (int k = 0; k < DEPTH; k++) begin
            exp = q_n.pop_front();
            pop_frame(1'b0, obs, got);
            n_cmp++;
            if (!got || obs !== exp) begin
                n_bad++;
                $display("FAIL ovf_drain%0d: got(seen=%b) d=0x%0h, expected d=0x%0h",
                         k, got, obs.data, exp.data);
            end
        end
        n_cmp++;
        if (valid_n !== 1'b0 || data_n !== 8'h44 || ovf_n !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_empty: got v=%b d=0x%0h ovf=%b, expected v=0 d=0x44 ovf=1",
                     valid_n, data_n, ovf_n);
        end
        clr_n = 1'b1;
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ovf_n !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b, expected 0", ovf_n);
        end
    endtask

    task automatic test_enable_abort();
        rx_frame_t exp, obs;
        bit got;
        send_bits(1'b0, 16'b1110, 4);
        en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut_n.r_state !== RX_IDLE) begin
            n_bad++;
            $display("FAIL enable_abort_state: got %0d, expected %0d", dut_n.r_state, RX_IDLE);
        end
        repeat (8 * BIT_CYC) @(negedge clk);
        en = 1'b1;
        q_n.push_back(mk(9'h03C, 1'b0, 1'b0, 1'b0));
        send_8n1(8'h3C);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (level_n !== 3'd1) begin
            n_bad++;
            $display("FAIL enable_level: got %0d, expected 1", level_n);
        end
        exp = q_n.pop_front();
        pop_frame(1'b0, obs, got);
        n_cmp++;
        if (!got || obs !== exp) begin
            n_bad++;
            $display("FAIL enable_frame: got(seen=%b) d=0x%0h p=%b f=%b b=%b, expected d=0x%0h",
                     got, obs.data, obs.parity_err, obs.frame_err, obs.brk, exp.data);
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_frame_t exp, obs;
        bit got;
        send_bits(1'b0, 16'b1110, 4);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        n_cmp++;
        if (level_n !== 3'd0) begin
            n_bad++;
            $display("FAIL rstmid_level0: got %0d, expected 0", level_n);
        end
        q_n.push_back(mk(9'h05A, 1'b0, 1'b0, 1'b0));
        send_8n1(8'h5A);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (level_n !== 3'd1) begin
            n_bad++;
            $display("FAIL rstmid_level1: got %0d, expected 1", level_n);
        end
        exp = q_n.pop_front();
        pop_frame(1'b0, obs, got);
        n_cmp++;
        if (!got || obs !== exp) begin
            n_bad++;
            $display("FAIL rstmid_frame: got(seen=%b) d=0x%0h p=%b f=%b b=%b, expected d=0x%0h p=0 f=0 b=0",
                     got, obs.data, obs.parity_err, obs.frame_err, obs.brk, exp.data);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity_even();
        test_break();
        test_glitch();
        test_overflow();
        test_enable_abort();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
